// File: rtl/lcd_bus_receiver.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// lcd_bus_receiver
//
// Listens to the panel-side bus of a 12864-style LCD controller and mirrors
// the graphics writes into a local framebuffer while tracking the panel mode.
// The bus pins are asynchronous to clk, so they pass through a two-stage
// synchronizer. A transaction is taken on the falling edge of the synchronized
// strobe, using the rs/rw/dat captured alongside the last en=1 sample.
//
// Ports
//   clk        : sole clock, rising edge
//   rst        : synchronous, active-high reset
//   rs, rw, en : bus control (rs=1 data, rw=1 read, en strobe)
//   dat[7:0]   : bus data, stable while en is high
//   fb_we      : one-cycle framebuffer write strobe
//   fb_addr    : {vert[5:0], horiz[3:0], byte}
//   fb_data    : framebuffer write data
//   display_on : display-control D bit
//   ext_mode   : extended instruction set selected
//   graphic_on : graphic display enabled (extended function set)
//   cmd_stb    : one-cycle pulse for every accepted instruction
//   cmd_code   : the accepted instruction byte
//   rd_err     : one-cycle pulse when a read transaction is seen
// -----------------------------------------------------------------------------
module lcd_bus_receiver #(
    parameter logic [3:0] H_WRAP = 4'd15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rs,
    input  logic        rw,
    input  logic        en,
    input  logic [7:0]  dat,
    output logic        fb_we,
    output logic [10:0] fb_addr,
    output logic [7:0]  fb_data,
    output logic        display_on,
    output logic        ext_mode,
    output logic        graphic_on,
    output logic        cmd_stb,
    output logic [7:0]  cmd_code,
    output logic        rd_err
);

    typedef struct packed {
        logic       en;
        logic       rs;
        logic       rw;
        logic [7:0] dat;
    } bus_t;

    typedef enum logic {
        A_IDLE,
        A_WAIT_H
    } addr_state_t;

    bus_t        sync1;
    bus_t        sync2;
    addr_state_t a_state;
    logic [5:0]  vert;
    logic [3:0]  horiz;
    logic        byte_sel;
    logic        gdram_sel;
    logic        fall;

    // sync2 still holds the last en=1 sample, so its rs/rw/dat belong to the
    // transaction that just ended.
    assign fall = sync2.en & ~sync1.en;

    // NOTE: all state here uses non-blocking assignments so every register
    // samples the pre-edge values; blocking would let later statements see
    // half-updated state (e.g. horiz incrementing against the new byte_sel).
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: every register, including the synchronizer, is cleared so
            // a strobe that was high when reset arrived cannot produce a
            // falling edge afterwards; en must be seen high again first.
            sync1      <= '0;
            sync2      <= '0;
            a_state    <= A_IDLE;
            vert       <= '0;
            horiz      <= '0;
            byte_sel   <= 1'b0;
            gdram_sel  <= 1'b0;
            display_on <= 1'b0;
            ext_mode   <= 1'b0;
            graphic_on <= 1'b0;
            fb_we      <= 1'b0;
            fb_addr    <= '0;
            fb_data    <= '0;
            cmd_stb    <= 1'b0;
            cmd_code   <= '0;
            rd_err     <= 1'b0;
        end else begin
            sync1   <= '{en: en, rs: rs, rw: rw, dat: dat};
            sync2   <= sync1;
            fb_we   <= 1'b0;
            cmd_stb <= 1'b0;
            rd_err  <= 1'b0;

            if (fall) begin
                if (sync2.rw) begin
                    // Reads are not mirrored; flag them and touch nothing else.
                    rd_err <= 1'b1;
                end else if (sync2.rs) begin
                    if (a_state == A_WAIT_H) begin
                        // Address sequence broken by data: drop the byte.
                        a_state <= A_IDLE;
                    end else if (gdram_sel) begin
                        fb_we    <= 1'b1;
                        fb_addr  <= {vert, horiz, byte_sel};
                        fb_data  <= sync2.dat;
                        byte_sel <= ~byte_sel;
                        // Each horizontal address holds two bytes; only the
                        // horizontal address auto-increments.
                        if (byte_sel) begin
                            horiz <= (horiz == H_WRAP) ? 4'd0 : horiz + 4'd1;
                        end
                    end
                end else begin
                    cmd_stb  <= 1'b1;
                    cmd_code <= sync2.dat;
                    if (a_state == A_WAIT_H && sync2.dat[7]) begin
                        // Second half of the GDRAM address pair.
                        horiz     <= sync2.dat[3:0];
                        byte_sel  <= 1'b0;
                        gdram_sel <= 1'b1;
                        a_state   <= A_IDLE;
                    end else if (sync2.dat[7]) begin
                        if (ext_mode) begin
                            vert    <= sync2.dat[5:0];
                            a_state <= A_WAIT_H;
                        end else begin
                            // DDRAM address: later data goes to text RAM.
                            gdram_sel <= 1'b0;
                        end
                    end else begin
                        a_state <= A_IDLE;
                        if (sync2.dat[7:5] == 3'b001) begin
                            ext_mode <= sync2.dat[2];
                            // The G bit is only honoured when already in the
                            // extended set and RE stays set.
                            if (ext_mode && sync2.dat[2]) begin
                                graphic_on <= sync2.dat[1];
                            end
                        end else if (!ext_mode && sync2.dat[7:3] == 5'b00001) begin
                            display_on <= sync2.dat[2];
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_lcd_bus_receiver.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_lcd_bus_receiver
//
// Stimulus drives directed bus transactions and pushes the strobe each one
// should cause into a queue; a monitor pops and compares whenever the DUT
// raises fb_we, cmd_stb or rd_err. Mode flags and reset values are compared
// directly after the relevant transactions.
// -----------------------------------------------------------------------------
module tb_lcd_bus_receiver;

    logic        clk = 1'b0;
    logic        rst;
    logic        rs;
    logic        rw;
    logic        en;
    logic [7:0]  dat;
    logic        fb_we;
    logic [10:0] fb_addr;
    logic [7:0]  fb_data;
    logic        display_on;
    logic        ext_mode;
    logic        graphic_on;
    logic        cmd_stb;
    logic [7:0]  cmd_code;
    logic        rd_err;

    lcd_bus_receiver #(.H_WRAP(4'd15)) dut (
        .clk        (clk),
        .rst        (rst),
        .rs         (rs),
        .rw         (rw),
        .en         (en),
        .dat        (dat),
        .fb_we      (fb_we),
        .fb_addr    (fb_addr),
        .fb_data    (fb_data),
        .display_on (display_on),
        .ext_mode   (ext_mode),
        .graphic_on (graphic_on),
        .cmd_stb    (cmd_stb),
        .cmd_code   (cmd_code),
        .rd_err     (rd_err)
    );

    always #5 clk = ~clk;

    typedef enum logic [2:0] {
        EV_FB  = 3'b100,
        EV_CMD = 3'b010,
        EV_RD  = 3'b001
    } ev_kind_t;

    typedef struct {
        ev_kind_t   kind;
        logic [10:0] addr;
        logic [7:0]  data;
    } ev_t;

    ev_t exp_q[$];
    int  checks = 0;
    int  errors = 0;

    task automatic check(input string name, input logic [31:0] actual,
                         input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Monitor: one pop per strobe cycle.
    initial begin
        ev_t e;
        forever begin
            @(negedge clk);
            if (fb_we || cmd_stb || rd_err) begin
                check("single_strobe", 32'(int'(fb_we) + int'(cmd_stb) + int'(rd_err)), 32'd1);
                if (exp_q.size() == 0) begin
                    check("unexpected_strobe", {29'd0, fb_we, cmd_stb, rd_err}, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("strobe_kind", {29'd0, fb_we, cmd_stb, rd_err}, {29'd0, e.kind});
                    if (e.kind == EV_FB) begin
                        check("fb_addr", {21'd0, fb_addr}, {21'd0, e.addr});
                        check("fb_data", {24'd0, fb_data}, {24'd0, e.data});
                    end else if (e.kind == EV_CMD) begin
                        check("cmd_code", {24'd0, cmd_code}, {24'd0, e.data});
                    end
                end
            end
        end
    end

    // One complete bus cycle: en high 3 clk, low 5 clk (outputs settle inside).
    task automatic bus_xfer(input logic t_rs, input logic t_rw, input logic [7:0] t_dat);
        @(negedge clk);
        rs  = t_rs;
        rw  = t_rw;
        dat = t_dat;
        en  = 1'b1;
        repeat (3) @(negedge clk);
        en = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    task automatic send_cmd(input logic [7:0] d);
        exp_q.push_back('{kind: EV_CMD, addr: 11'd0, data: d});
        bus_xfer(1'b0, 1'b0, d);
    endtask

    task automatic send_data(input logic [7:0] d, input logic expect_we,
                             input logic [10:0] a);
        if (expect_we) exp_q.push_back('{kind: EV_FB, addr: a, data: d});
        bus_xfer(1'b1, 1'b0, d);
    endtask

    task automatic send_read(input logic [7:0] d);
        exp_q.push_back('{kind: EV_RD, addr: 11'd0, data: 8'd0});
        bus_xfer(1'b0, 1'b1, d);
    endtask

    task automatic check_flags(input string tag, input logic d, input logic e,
                               input logic g);
        check({tag, "_display_on"}, {31'd0, display_on}, {31'd0, d});
        check({tag, "_ext_mode"},   {31'd0, ext_mode},   {31'd0, e});
        check({tag, "_graphic_on"}, {31'd0, graphic_on}, {31'd0, g});
    endtask

    task automatic check_reset_values(input string tag);
        check_flags(tag, 1'b0, 1'b0, 1'b0);
        check({tag, "_fb_addr"},  {21'd0, fb_addr},  32'd0);
        check({tag, "_fb_data"},  {24'd0, fb_data},  32'd0);
        check({tag, "_cmd_code"}, {24'd0, cmd_code}, 32'd0);
        check({tag, "_strobes"},  {29'd0, fb_we, cmd_stb, rd_err}, 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        rs  = 1'b0;
        rw  = 1'b0;
        en  = 1'b0;
        dat = 8'h00;
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        rst = 1'b0;

        // Data before any GDRAM address is dropped; unlisted instruction.
        send_data(8'h77, 1'b0, 11'h000);
        send_cmd(8'h01);
        check_flags("clear", 1'b0, 1'b0, 1'b0);

        // Init sequence.
        send_cmd(8'h30);
        send_cmd(8'h0C);
        check_flags("disp_on", 1'b1, 1'b0, 1'b0);
        send_cmd(8'h36);
        check_flags("ext1", 1'b1, 1'b1, 1'b0);
        send_cmd(8'h36);
        check_flags("ext2", 1'b1, 1'b1, 1'b1);

        // vert 5, horiz 3, then three bytes (third shows horiz advanced to 4).
        send_cmd(8'h85);
        send_cmd(8'h83);
        send_data(8'hAA, 1'b1, 11'h0A6);
        send_data(8'h55, 1'b1, 11'h0A7);
        send_data(8'h12, 1'b1, 11'h0A8);

        // Horizontal wrap at 15, vert stays 0.
        send_cmd(8'h80);
        send_cmd(8'h8F);
        send_data(8'h01, 1'b1, 11'h01E);
        send_data(8'h02, 1'b1, 11'h01F);
        send_data(8'h03, 1'b1, 11'h000);
        send_data(8'h04, 1'b1, 11'h001);

        // Vertical only, then data: dropped; next data uses vert 5, horiz 1.
        send_cmd(8'h85);
        send_data(8'h11, 1'b0, 11'h000);
        send_data(8'h21, 1'b1, 11'h0A2);

        // Display control is ignored in extended mode.
        send_cmd(8'h08);
        check_flags("ext_ignore", 1'b1, 1'b1, 1'b1);

        // Back to basic set: graphic_on unchanged; DDRAM address deselects GDRAM.
        send_cmd(8'h30);
        check_flags("basic", 1'b1, 1'b0, 1'b1);
        send_cmd(8'h80);
        send_data(8'h22, 1'b0, 11'h000);
        send_cmd(8'h08);
        check_flags("disp_off", 1'b0, 1'b0, 1'b1);

        // Read transaction.
        send_read(8'hFF);
        check_flags("read", 1'b0, 1'b0, 1'b1);

        // Reset in the middle of a data write.
        @(negedge clk);
        rs  = 1'b1;
        rw  = 1'b0;
        dat = 8'h5A;
        en  = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        en = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check_reset_values("midreset");

        // Decoding resumes normally.
        send_cmd(8'h0C);
        check_flags("post_reset", 1'b1, 1'b0, 1'b0);

        repeat (4) @(negedge clk);
        check("pending_events", exp_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/lcd_bus_receiver.md
LCD_BUS_RECEIVER -- requirements
Module: lcd_bus_receiver

Interface
REQ-001 SHALL have parameter H_WRAP, default 15: last horizontal GDRAM word address before wrap to 0.
REQ-002 SHALL have port clk, input, 1: sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-004 SHALL have ports rs, rw, en, input, 1 each: panel-side bus signals as driven by the 12864 controller (rs=1 data, rw=1 read, en strobe).
REQ-005 SHALL have port dat, input, 8: bus data, stable while en high.
REQ-006 SHALL have ports fb_we (1), fb_addr (11), fb_data (8), outputs: framebuffer write port, fb_addr = {vert[5:0], horiz[3:0], byte}.
REQ-007 SHALL have outputs display_on, ext_mode, graphic_on, 1 each: decoded panel mode flags.
REQ-008 SHALL have outputs cmd_stb (1) and cmd_code (8): one-cycle pulse plus byte for every accepted instruction (rs=0, rw=0).
REQ-009 SHALL have output rd_err, 1: one-cycle pulse when a rw=1 transaction is seen.

Function
REQ-010 SHALL pass en, rs, rw, dat through a 2-stage synchronizer; the transaction edge is en_sync falling (stage2=1, stage1=0).
REQ-011 SHALL use the rs/rw/dat values held in the synchronizer stage captured alongside the last en_sync=1 sample; bus requires en high >= 2 clk, low >= 2 clk.
REQ-012 SHALL assert all transaction outputs exactly 1 clk after the cycle in which the falling edge is detected; <= 4 clk from pin edge.
REQ-013 SHALL, on rw=1, pulse rd_err and change no other state.
REQ-014 Function set (dat[7:5]=001): ext_mode <= dat[2]; graphic_on <= dat[1] only if ext_mode already 1 and dat[2]=1; otherwise graphic_on unchanged.
REQ-015 Display control (ext_mode=0, dat[7:3]=00001): display_on <= dat[2]; other bits ignored.
REQ-016 Address FSM states: A_IDLE, A_WAIT_H; reset state A_IDLE.
REQ-017 A_IDLE, ext_mode=1, instruction dat[7]=1: vert <= dat[5:0], go A_WAIT_H.
REQ-018 A_WAIT_H, instruction dat[7]=1: horiz <= dat[3:0], byte <= 0, gdram_sel <= 1, go A_IDLE.
REQ-019 A_WAIT_H, any other instruction or a data write: go A_IDLE; instruction executes normally; data write dropped (no fb_we).
REQ-020 Instruction dat[7]=1 with ext_mode=0 (DDRAM address): gdram_sel <= 0.
REQ-021 Data write (rs=1) with gdram_sel=1 in A_IDLE: fb_we=1 for 1 clk, fb_addr={vert,horiz,byte}, fb_data=dat; then byte toggles.
REQ-022 After the byte=1 write: horiz increments; horiz==H_WRAP wraps to 0; vert never changes on auto-increment.
REQ-023 Data write with gdram_sel=0: dropped, no fb_we.
REQ-024 Unlisted instructions (clear, home, entry mode, etc.): cmd_stb only, no state change.
REQ-025 fb_we, cmd_stb, rd_err SHALL never be high in the same cycle; each high at most 1 clk per transaction.
REQ-026 Data 1 clk after en falling edge is not held beyond that cycle; fb_addr/fb_data may hold last value when fb_we=0.

Reset
REQ-027 rst=1 SHALL clear synchronizer stages to 0, FSM to A_IDLE, vert/horiz/byte/gdram_sel to 0, display_on/ext_mode/graphic_on to 0, fb_we/cmd_stb/rd_err to 0, fb_addr/fb_data/cmd_code to 0.
REQ-028 rst asserted mid-transaction (en high) SHALL discard that transaction; first edge after release is detected only after en_sync observed high post-reset.

Verification
REQ-029 Init sequence 0x30, 0x0C, 0x36, 0x36 -> after 0x0C display_on=1; after first 0x36 ext_mode=1, graphic_on=0; after second graphic_on=1; four cmd_stb pulses.
REQ-030 Ext mode, cmds 0x85, 0x83, data 0xAA, 0x55 -> fb_we at fb_addr 0x0A6 data 0xAA, then 0x0A7 data 0x55; horiz becomes 4.
REQ-031 Set vert 0, horiz 15, write 4 data bytes -> addrs 0x01E, 0x01F, 0x000, 0x001 (wrap, vert unchanged).
REQ-032 Cmd 0x85 then data 0x11 (no horiz byte) -> no fb_we, FSM A_IDLE; following data also dropped if gdram_sel was 0.
REQ-033 rw=1 strobe with dat=0xFF -> rd_err pulse 1 clk, no fb_we/cmd_stb, flags unchanged.
REQ-034 rst pulsed while en high during data write -> no fb_we; all outputs at REQ-027 values; next full transaction decoded normally.
